spi_ram_slave_burst: RTL

//  Second-generation SPI slave with embedded single-port RAM; replaces the fixed 8-bit slave/RAM pair.

---
 rtl/spi_ram_slave_burst.sv | 116 +++++++++++
 1 files changed

// File: rtl/spi_ram_slave_burst.sv
// spi_ram_slave_burst: SPI slave with embedded single-port RAM, configurable width/depth/dummy cycles/burst
module spi_ram_slave_burst #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RD_DUMMY = 2,
  parameter int BURST_EN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_err
);
  localparam int SH_W = ADDR_W > DATA_W ? ADDR_W : DATA_W;
  localparam int CW   = $clog2((SH_W > RD_DUMMY ? SH_W : RD_DUMMY) + 1);
  typedef enum logic [2:0] {IDLE, CMD, WADDR, WDATA, RADDR, RDUMMY, RDATA, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [SH_W-1:0] sh_q, sh_d, shin;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic miso_q, miso_d, err_q, err_d, we, load;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_word_q, wdata;
  assign MISO = miso_q;
  assign busy = state_q != IDLE;
  assign frame_err = err_q;
  // Next state, shift/count datapath and pointer updates; a word load also serves burst continuation
  always_comb begin
    state_d = state_q;
    cnt_inc = cnt_q + CW'(1);
    cnt_d = cnt_q;
    shin = {sh_q[SH_W-2:0], MOSI};
    sh_d = shin;
    wdata = shin[DATA_W-1:0];
    miso_d = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    we = 1'b0;
    err_d = 1'b0;
    load = !SS_n && ((state_q == RDUMMY && cnt_q == CW'(RD_DUMMY - 1)) ||
                     (state_q == RDATA && cnt_q == CW'(DATA_W - 1) && BURST_EN != 0));
    if (SS_n) begin
      state_d = IDLE;
      cnt_d = '0;
      err_d = state_q == CMD ||
              ((state_q == WADDR || state_q == RADDR || state_q == WDATA) && cnt_q != '0);
    end else begin
      case (state_q)
        IDLE: state_d = CMD;
        CMD: state_d = sh_q[0] ? (MOSI ? RDUMMY : RADDR) : (MOSI ? WDATA : WADDR);
        WADDR, RADDR: begin
          cnt_d = cnt_inc;
          if (cnt_q == CW'(ADDR_W - 1)) begin
            state_d = DONE;
            cnt_d = '0;
            wr_ptr_d = state_q == WADDR ? shin[ADDR_W-1:0] : wr_ptr_q;
            rd_ptr_d = state_q == RADDR ? shin[ADDR_W-1:0] : rd_ptr_q;
          end
        end
        WDATA: begin
          cnt_d = cnt_inc;
          if (cnt_q == CW'(DATA_W - 1)) begin
            we = 1'b1;
            cnt_d = '0;
            wr_ptr_d = BURST_EN != 0 ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
            state_d = BURST_EN != 0 ? WDATA : DONE;
          end
        end
        RDUMMY: cnt_d = cnt_inc;
        RDATA: begin
          if (cnt_q == CW'(DATA_W - 1)) state_d = DONE;
          else begin
            miso_d = sh_q[DATA_W-1];
            sh_d = sh_q << 1;
            cnt_d = cnt_inc;
          end
        end
        default: ;
      endcase
      if (load) begin
        state_d = RDATA;
        cnt_d = '0;
        miso_d = rd_word_q[DATA_W-1];
        sh_d = SH_W'(rd_word_q) << 1;
        rd_ptr_d = BURST_EN != 0 ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
      end
    end
  end
  // Control and datapath registers, cleared by async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      miso_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      miso_q <= miso_d;
      err_q <= err_d;
    end
  end
  // Single-port RAM: write a completed word, otherwise keep prefetching the word at rd_ptr
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= wdata;
    else rd_word_q <= mem[rd_ptr_q];
  end
endmodule
